// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if
//
// Bundles the result-source handshake and the common data bus (CDB)
// broadcast for cdb_arbiter. Clock and reset are not part of the bundle.
//
// Signals
//   flush      pipeline flush; discards every buffered result
//   src_valid  [2:0]   per-source result valid (0=ALU, 1=MUL, 2=LSU)
//   src_ready  [2:0]   per-source accept
//   src_tag    [17:0]  destination tags, source i at [6i+5:6i]
//   src_data   [95:0]  result data, source i at [32i+31:32i]
//   cdb_valid          broadcast valid (RF write enable / IQ wakeup)
//   cdb_tag    [5:0]   broadcast physical register tag
//   cdb_data   [31:0]  broadcast result data
//
// Modports
//   master  the execution-unit side that produces results and listens on
//           the CDB
//   slave   the arbiter itself
// ---------------------------------------------------------------------------
interface cdb_arbiter_if;

  logic        flush;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic [17:0] src_tag;
  logic [95:0] src_data;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;

  modport master (
    output flush,
    output src_valid,
    output src_tag,
    output src_data,
    input  src_ready,
    input  cdb_valid,
    input  cdb_tag,
    input  cdb_data
  );

  modport slave (
    input  flush,
    input  src_valid,
    input  src_tag,
    input  src_data,
    output src_ready,
    output cdb_valid,
    output cdb_tag,
    output cdb_data
  );

endinterface

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Collects results from three execution sources (ALU, MUL, LSU), buffers
// each source in its own small FIFO and broadcasts one result per cycle on
// the common data bus, picking among non-empty FIFOs in round-robin order.
// The broadcast is registered, so a result that has to go through a FIFO
// reaches the bus two edges after it is presented.
//
// Parameters
//   FIFO_DEPTH  entries per source FIFO, 2..8
//   NUM_SRC     number of result sources; the bus widths are fixed for 3
//
// Ports
//   clk    clock, every state change on its rising edge
//   rst_n  asynchronous active-low reset; empties all FIFOs, clears the
//          round-robin pointer and the CDB registers
//   bus    cdb_arbiter_if.slave: source handshake, flush and CDB outputs
//
// Optional feature
//   CDB_BYPASS_EN  when defined, a beat arriving at an empty FIFO may be
//                  granted in the same cycle and written straight into the
//                  CDB registers, skipping the FIFO (one-cycle latency).
//                  When undefined, every beat is buffered first.
// ---------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int NUM_SRC    = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  cdb_arbiter_if.slave bus
);

  // Pointer width covers FIFO_DEPTH entries; the counter has to reach
  // FIFO_DEPTH itself, hence one more value.
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Per-source FIFO storage and bookkeeping
  logic [5:0]       r_fifoTag  [NUM_SRC][FIFO_DEPTH];
  logic [31:0]      r_fifoData [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0] r_rdPtr    [NUM_SRC];
  logic [PTR_W-1:0] r_wrPtr    [NUM_SRC];
  logic [CNT_W-1:0] r_count    [NUM_SRC];

  // Arbitration state and registered CDB outputs
  logic [1:0]  r_rrPtr;
  logic        r_cdbValid;
  logic [5:0]  r_cdbTag;
  logic [31:0] r_cdbData;

  // Unpacked view of the source buses
  logic [5:0]  w_inTag  [NUM_SRC];
  logic [31:0] w_inData [NUM_SRC];

  // Per-source control
  logic [NUM_SRC-1:0] w_ready;
  logic [NUM_SRC-1:0] w_accept;
  logic [NUM_SRC-1:0] w_cand;
  logic [NUM_SRC-1:0] w_grantVec;
  logic [NUM_SRC-1:0] w_bypass;
  logic [NUM_SRC-1:0] w_enq;
  logic [NUM_SRC-1:0] w_deq;

  // Arbitration result
  logic        w_grantAny;
  logic [1:0]  w_grantIdx;
  logic [1:0]  w_rrNext;
  logic [5:0]  w_selTag;
  logic [31:0] w_selData;

  // Wrapping pointer increment; works for depths that are not powers of two.
  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  // Per-source handshake. Ready is purely combinational from the count and
  // flush, so a full FIFO never takes a beat even when its head is leaving
  // in the same cycle. A beat that is bypassed straight onto the CDB must
  // not also be written into the FIFO.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign w_inTag[gi]  = bus.src_tag[6*gi +: 6];
    assign w_inData[gi] = bus.src_data[32*gi +: 32];
    assign w_ready[gi]  = (r_count[gi] < CNT_FULL) && !bus.flush;
    assign w_accept[gi] = bus.src_valid[gi] && w_ready[gi];
`ifdef CDB_BYPASS_EN
    assign w_cand[gi]   = !bus.flush && ((r_count[gi] != '0) || w_accept[gi]);
    assign w_bypass[gi] = w_grantVec[gi] && (r_count[gi] == '0);
`else
    assign w_cand[gi]   = !bus.flush && (r_count[gi] != '0);
    assign w_bypass[gi] = 1'b0;
`endif
    assign w_enq[gi]    = w_accept[gi] && !w_bypass[gi];
    assign w_deq[gi]    = w_grantVec[gi] && (r_count[gi] != '0);
  end

  assign bus.src_ready = w_ready;

  // Round-robin pick: the pointer names the source with highest priority
  // this cycle and the other two follow in ascending order modulo 3. The
  // three rotations are spelled out because there are only three sources
  // and the explicit table is easier to read than modular index arithmetic.
  always_comb begin
    w_grantAny = 1'b0;
    w_grantIdx = 2'd0;
    w_grantVec = '0;
    case (r_rrPtr)
      2'd1: begin
        if (w_cand[1]) begin
          w_grantAny = 1'b1;
          w_grantIdx = 2'd1;
        end else if (w_cand[2]) begin
          w_grantAny = 1'b1;
          w_grantIdx = 2'd2;
        end else if (w_cand[0]) begin
          w_grantAny = 1'b1;
          w_grantIdx = 2'd0;
        end
      end
      2'd2: begin
        if (w_cand[2]) begin
          w_grantAny = 1'b1;
          w_grantIdx = 2'd2;
        end else if (w_cand[0]) begin
          w_grantAny = 1'b1;
          w_grantIdx = 2'd0;
        end else if (w_cand[1]) begin
          w_grantAny = 1'b1;
          w_grantIdx = 2'd1;
        end
      end
      default: begin
        if (w_cand[0]) begin
          w_grantAny = 1'b1;
          w_grantIdx = 2'd0;
        end else if (w_cand[1]) begin
          w_grantAny = 1'b1;
          w_grantIdx = 2'd1;
        end else if (w_cand[2]) begin
          w_grantAny = 1'b1;
          w_grantIdx = 2'd2;
        end
      end
    endcase
    if (w_grantAny) begin
      w_grantVec[w_grantIdx] = 1'b1;
    end
  end

  // The source just served drops to lowest priority next cycle.
  assign w_rrNext = (w_grantIdx == 2'd2) ? 2'd0 : w_grantIdx + 2'd1;

  // Entry to broadcast: normally the head of the granted FIFO; in a bypass
  // grant the FIFO is empty and the incoming beat is taken instead.
  always_comb begin
    w_selTag  = r_fifoTag[w_grantIdx][r_rdPtr[w_grantIdx]];
    w_selData = r_fifoData[w_grantIdx][r_rdPtr[w_grantIdx]];
    if (w_bypass[w_grantIdx]) begin
      w_selTag  = w_inTag[w_grantIdx];
      w_selData = w_inData[w_grantIdx];
    end
  end

  // FIFO payload storage. It carries no reset: an entry is only ever read
  // after being written, and emptiness is tracked by the counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_enq[i]) begin
        r_fifoTag[i][r_wrPtr[i]]  <= w_inTag[i];
        r_fifoData[i][r_wrPtr[i]] <= w_inData[i];
      end
    end
  end

  // FIFO counters and pointers. Flush empties every FIFO at the edge; a
  // simultaneous enqueue and dequeue leaves the count where it was while
  // both pointers advance, so order is preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_count[i] <= '0;
        r_rdPtr[i] <= '0;
        r_wrPtr[i] <= '0;
      end
    end else if (bus.flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_count[i] <= '0;
        r_rdPtr[i] <= '0;
        r_wrPtr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_enq[i]) begin
          r_wrPtr[i] <= ptrInc(r_wrPtr[i]);
        end
        if (w_deq[i]) begin
          r_rdPtr[i] <= ptrInc(r_rdPtr[i]);
        end
        case ({w_enq[i], w_deq[i]})
          2'b10:   r_count[i] <= r_count[i] + CNT_ONE;
          2'b01:   r_count[i] <= r_count[i] - CNT_ONE;
          default: r_count[i] <= r_count[i];
        endcase
      end
    end
  end

  // CDB output registers and round-robin pointer. Valid is a one-cycle
  // pulse per grant; tag and data keep the last broadcast value when idle
  // so downstream logic never sees spurious toggles. Flush kills the pulse
  // and freezes the pointer (no grant can occur while flushing anyway).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr    <= 2'd0;
      r_cdbValid <= 1'b0;
      r_cdbTag   <= 6'd0;
      r_cdbData  <= 32'd0;
    end else if (bus.flush) begin
      r_cdbValid <= 1'b0;
    end else begin
      r_cdbValid <= w_grantAny;
      if (w_grantAny) begin
        r_rrPtr   <= w_rrNext;
        r_cdbTag  <= w_selTag;
        r_cdbData <= w_selData;
      end
    end
  end

  assign bus.cdb_valid = r_cdbValid;
  assign bus.cdb_tag   = r_cdbTag;
  assign bus.cdb_data  = r_cdbData;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed bench for cdb_arbiter in its default build (FIFO_DEPTH=2, no
// bypass). Inputs are driven and outputs sampled on the falling clock edge,
// so every sample reflects the state after the preceding rising edge.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

  logic clk;
  logic rst_n;

  cdb_arbiter_if bus();

  cdb_arbiter #(
    .FIFO_DEPTH(2),
    .NUM_SRC(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  // Scoreboard state for the MUL streaming test
  logic [5:0] mulQ[$];
  int         mulIn  = 0;
  int         mulOut = 0;

  // Safety net in case the run ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Every comparison goes through here
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Data for a beat is derived from its tag so it can be predicted anywhere
  function automatic logic [31:0] dataFor(input logic [5:0] t);
    return 32'hC0DE_0000 | 32'(t);
  endfunction

  // Drive all three sources at once
  task automatic applyStimulus(input logic [2:0] valid, input logic [5:0] t0,
                               input logic [5:0] t1, input logic [5:0] t2);
    bus.src_valid = valid;
    bus.src_tag   = {t2, t1, t0};
    bus.src_data  = {dataFor(t2), dataFor(t1), dataFor(t0)};
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyReset();
    rst_n    = 1'b0;
    bus.flush = 1'b0;
    applyStimulus(3'b000, 6'd0, 6'd0, 6'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Checks any MUL-tagged broadcast (tags 32..47) against the scoreboard
  task automatic observeMul();
    if (bus.cdb_valid && bus.cdb_tag >= 6'd32 && bus.cdb_tag < 6'd48) begin
      mulOut++;
      if (mulQ.size() == 0) begin
        checkOutput("mulExtraBeat", 32'(bus.cdb_tag), 32'd0);
      end else begin
        checkOutput("mulOrder", 32'(bus.cdb_tag), 32'(mulQ.pop_front()));
      end
    end
  endtask

  // Ready pattern for MUL+LSU streaming from empty with rr=0: both FIFOs
  // fill, then the two sources alternate being full.
  function automatic logic [2:0] expReady(input int cyc);
    if (cyc < 2)          return 3'b111;
    else if (cyc % 2 == 0) return 3'b011;
    else                  return 3'b101;
  endfunction

  initial begin
    int grants[3];
    logic [5:0] mulTag;

    // ---------------- reset state ----------------
    rst_n     = 1'b0;
    bus.flush = 1'b0;
    applyStimulus(3'b000, 6'd0, 6'd0, 6'd0);
    tick();
    tick();
    checkOutput("rstValid", 32'(bus.cdb_valid), 32'd0);
    checkOutput("rstTag",   32'(bus.cdb_tag),   32'd0);
    checkOutput("rstData",  bus.cdb_data,       32'd0);
    checkOutput("rstReady", 32'(bus.src_ready), 32'd7);
    rst_n = 1'b1;

    // ---------------- single ALU beat, two-edge latency ----------------
    applyStimulus(3'b001, 6'd5, 6'd0, 6'd0);
    bus.src_data[31:0] = 32'hDEAD_BEEF;
    tick();
    applyStimulus(3'b000, 6'd0, 6'd0, 6'd0);
    checkOutput("latEdge1Valid", 32'(bus.cdb_valid), 32'd0);
    tick();
    checkOutput("latEdge2Valid", 32'(bus.cdb_valid), 32'd1);
    checkOutput("latEdge2Tag",   32'(bus.cdb_tag),   32'd5);
    checkOutput("latEdge2Data",  bus.cdb_data,       32'hDEAD_BEEF);
    tick();
    checkOutput("latIdleValid", 32'(bus.cdb_valid), 32'd0);
    checkOutput("latHoldTag",   32'(bus.cdb_tag),   32'd5);

    // ---------------- one beat per source, round-robin order ----------------
    applyReset();
    applyStimulus(3'b111, 6'd1, 6'd2, 6'd3);
    tick();
    applyStimulus(3'b000, 6'd0, 6'd0, 6'd0);
    checkOutput("rrBufferedValid", 32'(bus.cdb_valid), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput("rrSeqValid", 32'(bus.cdb_valid), 32'd1);
      checkOutput("rrSeqTag",   32'(bus.cdb_tag),   32'(k));
      checkOutput("rrSeqData",  bus.cdb_data,       dataFor(6'(k)));
    end
    // Pointer back at 0: with ALU and LSU both pending, ALU must win first
    applyStimulus(3'b101, 6'd10, 6'd0, 6'd12);
    tick();
    applyStimulus(3'b000, 6'd0, 6'd0, 6'd0);
    checkOutput("rrGapValid", 32'(bus.cdb_valid), 32'd0);
    tick();
    checkOutput("rrEndFirst", 32'(bus.cdb_tag), 32'd10);
    tick();
    checkOutput("rrEndSecond", 32'(bus.cdb_tag), 32'd12);
    tick();
    checkOutput("rrEndIdle", 32'(bus.cdb_valid), 32'd0);

    // ---------------- MUL streaming under LSU contention ----------------
    mulTag = 6'd32;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc > 0) observeMul();
      applyStimulus(3'b110, 6'd0, mulTag, 6'd48);
      #1;
      checkOutput("mulReady", 32'(bus.src_ready), 32'(expReady(cyc)));
      if (bus.src_ready[1]) begin
        mulQ.push_back(mulTag);
        mulIn++;
        mulTag = mulTag + 6'd1;
      end
      tick();
    end
    observeMul();
    applyStimulus(3'b000, 6'd0, 6'd0, 6'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      observeMul();
    end
    checkOutput("mulAccepted",  32'(mulIn), 32'd6);
    checkOutput("mulDelivered", 32'(mulOut), 32'(mulIn));
    checkOutput("mulQEmpty",    32'(mulQ.size()), 32'd0);

    // ---------------- flush with four beats buffered ----------------
    applyStimulus(3'b011, 6'd20, 6'd21, 6'd0);
    tick();
    applyStimulus(3'b111, 6'd22, 6'd23, 6'd24);
    tick();
    checkOutput("preFlushValid", 32'(bus.cdb_valid), 32'd1);
    bus.flush = 1'b1;
    applyStimulus(3'b111, 6'd25, 6'd26, 6'd27);
    #1;
    checkOutput("flushReady", 32'(bus.src_ready), 32'd0);
    tick();
    bus.flush = 1'b0;
    applyStimulus(3'b000, 6'd0, 6'd0, 6'd0);
    #1;
    checkOutput("postFlushValid", 32'(bus.cdb_valid), 32'd0);
    checkOutput("postFlushReady", 32'(bus.src_ready), 32'd7);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("noStaleValid", 32'(bus.cdb_valid), 32'd0);
    end

    // ---------------- asynchronous reset mid-broadcast ----------------
    applyStimulus(3'b111, 6'd30, 6'd31, 6'd33);
    tick();
    applyStimulus(3'b000, 6'd0, 6'd0, 6'd0);
    tick();
    checkOutput("preRstValid", 32'(bus.cdb_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstValid", 32'(bus.cdb_valid), 32'd0);
    checkOutput("asyncRstTag",   32'(bus.cdb_tag),   32'd0);
    checkOutput("asyncRstReady", 32'(bus.src_ready), 32'd7);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("postRstEmpty", 32'(bus.cdb_valid), 32'd0);
    end

    // ---------------- all sources saturated for 30 grants ----------------
    applyReset();
    grants = '{0, 0, 0};
    applyStimulus(3'b111, 6'd1, 6'd2, 6'd3);
    tick();
    for (int k = 0; k < 30; k++) begin
      tick();
      checkOutput("satValid", 32'(bus.cdb_valid), 32'd1);
      checkOutput("satSeq",   32'(bus.cdb_tag),   32'((k % 3) + 1));
      if (bus.cdb_valid && bus.cdb_tag >= 6'd1 && bus.cdb_tag <= 6'd3) begin
        grants[bus.cdb_tag - 6'd1]++;
      end
    end
    applyStimulus(3'b000, 6'd0, 6'd0, 6'd0);
    checkOutput("satGrantsAlu", 32'(grants[0]), 32'd10);
    checkOutput("satGrantsMul", 32'(grants[1]), 32'd10);
    checkOutput("satGrantsLsu", 32'(grants[2]), 32'd10);
    tick();
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
